// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared FSM encoding, bit-timing helper and frame-length constants
//            for the word-oriented UART transmitter.
//            Frame length depends on macro UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_state_w = 4;

    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_latch = 4'd1;
    localparam logic [3:0] c_st_req   = 4'd2;
    localparam logic [3:0] c_st_wait  = 4'd3;
    localparam logic [3:0] c_st_start = 4'd4;
    localparam logic [3:0] c_st_data  = 4'd5;
    localparam logic [3:0] c_st_par   = 4'd6;
    localparam logic [3:0] c_st_stop  = 4'd7;
    localparam logic [3:0] c_st_fin   = 4'd8;

    localparam int unsigned c_data_bits = 8;
`ifdef UART_PARITY_EN
    localparam int unsigned c_frame_bits = 11;
`else
    localparam int unsigned c_frame_bits = 10;
`endif

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Free-running bit-period counter with a one-cycle tick on the last
//            clock of each bit; restart forces the count back to zero.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_tx
// Purpose  : Reads 16-bit words from an upstream buffer and sends each as two
//            8N1 frames (high byte first). Even parity enabled by UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 27000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned SETTLE   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic [15:0] data_in,
    input  logic        ended,
    output logic        rd_clk,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned c_clks_per_bit = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned c_settle_w     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE - 1);

    logic [c_state_w-1:0]  r_state;
    logic [15:0]           r_shadow;
    logic                  r_last;
    logic                  r_byte_idx;
    logic [2:0]            r_bit_idx;
    logic [c_settle_w-1:0] r_settle;
    logic                  r_tx;
    logic                  r_rd_clk;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic [7:0]            w_byte;
    logic                  w_tx_state;
    logic                  w_busy_state;

    uart_baud_tick #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_baud_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (r_state == c_st_req),
        .o_tick    (w_tick)
    );

    assign w_byte = r_byte_idx ? r_shadow[7:0] : r_shadow[15:8];

    always_comb begin
        w_tx_state = 1'b1;
        case (r_state)
            c_st_start: w_tx_state = 1'b0;
            c_st_data:  w_tx_state = w_byte[r_bit_idx];
            c_st_par:   w_tx_state = ^w_byte;
            default:    w_tx_state = 1'b1;
        endcase
    end

    assign w_busy_state = (r_state == c_st_latch) || (r_state == c_st_req)  ||
                          (r_state == c_st_start) || (r_state == c_st_data) ||
                          (r_state == c_st_par)   || (r_state == c_st_stop);

    // Outputs are registered from the current state, so the whole line trails
    // the FSM by one clock uniformly and every bit keeps its full width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_shadow   <= '0;
            r_last     <= 1'b0;
            r_byte_idx <= 1'b0;
            r_bit_idx  <= '0;
            r_settle   <= '0;
            r_tx       <= 1'b1;
            r_rd_clk   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_clk <= (r_state == c_st_req);
            r_busy   <= w_busy_state;
            r_tx     <= w_tx_state;
            r_settle <= '0;
            case (r_state)
                c_st_idle: begin
                    if (rd_en && !r_done) r_state <= c_st_latch;
                end
                c_st_latch: begin
                    r_shadow   <= data_in;
                    r_last     <= ended;
                    r_byte_idx <= 1'b0;
                    r_state    <= c_st_req;
                end
                c_st_req: begin
                    r_bit_idx <= '0;
                    r_state   <= c_st_start;
                end
                c_st_start: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= c_st_par;
`else
                            r_state <= c_st_stop;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                c_st_par: begin
                    if (w_tick) r_state <= c_st_stop;
                end
                c_st_stop: begin
                    if (w_tick) begin
                        if (!r_byte_idx) begin
                            r_byte_idx <= 1'b1;
                            r_state    <= c_st_start;
                        end else if (r_last) begin
                            r_state <= c_st_fin;
                        end else begin
                            r_state <= c_st_wait;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_settle == c_settle_last) begin
                        r_state <= rd_en ? c_st_latch : c_st_idle;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                c_st_fin: begin
                    r_done  <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign rd_clk = r_rd_clk;
    assign tx     = r_tx;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_tx
// Purpose  : Self-checking bench: upstream buffer model plus a UART receiver
//            model that checks every transmitted bit against expected bytes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int CPB = 27000000 / 115200;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
    localparam int WORD_LEN_LIT = 5148;
`else
    localparam int FB = 10;
    localparam int WORD_LEN_LIT = 4680;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [15:0] data_in;
    logic        ended;
    logic        rd_clk;
    logic        tx;
    logic        busy;
    logic        done;

    uart_word_tx dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .data_in (data_in),
        .ended   (ended),
        .rd_clk  (rd_clk),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream buffer model: advances on each rd_clk rising edge.
    logic [15:0] up_words[$];
    int          up_idx;
    int          up_last;
    bit          up_off;

    task automatic drive_up();
        rd_en   = !up_off && (up_idx < up_words.size());
        data_in = (up_idx < up_words.size()) ? up_words[up_idx] : 16'h0000;
        ended   = (up_idx >= up_last);
    endtask

    initial begin : upstream
        forever begin
            @(posedge rd_clk);
            up_idx++;
            drive_up();
        end
    end

    int rd_pulses;
    initial begin : rd_mon
        forever begin
            @(posedge rd_clk);
            rd_pulses++;
            @(negedge clk);
            @(negedge clk);
            check("rd_clk_width", rd_clk, 1'b0);
        end
    end

    // Expected-byte scoreboard and receiver model.
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         last_len;

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    initial begin : rx_mon
        int         pos;
        int         t0;
        bit         at_start;
        bit         aborted;
        bit         bz;
        logic       seen;
        logic [7:0] expb;
        logic [7:0] got;
        logic [10:0] fr;
        pos = 0; t0 = 0; at_start = 0;
        forever begin
            if (!at_start) @(negedge clk);
            at_start = 0;
            if (!reset && tx === 1'b0) begin
                check("frame_expected", exp_q.size() != 0, 1'b1);
                expb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                fr = frame_of(expb);
                if (pos == 0) t0 = cyc;
                aborted = 0; bz = 1; got = 8'h00;
                for (int b = 0; b < FB; b++) begin
                    seen = fr[b];
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (reset) begin aborted = 1; break; end
                        if (tx !== fr[b] && seen === fr[b]) seen = tx;
                        if (busy !== 1'b1) bz = 0;
                        if (c == CPB / 2 && b >= 1 && b <= 8) got[b-1] = tx;
                    end
                    if (aborted) break;
                    check($sformatf("byte%02h_bit%0d", expb, b), seen, fr[b]);
                end
                if (aborted) begin
                    pos = 0;
                end else begin
                    check($sformatf("busy_in_frame_%02h", expb), bz, 1'b1);
                    rx_q.push_back(got);
                    if (pos == 0) begin
                        pos = 1;
                        @(negedge clk);
                        check("no_gap_hi_lo", tx, 1'b0);
                        at_start = 1;
                    end else begin
                        pos = 0;
                        last_len = cyc - t0 + 1;
                        check("word_len", last_len, 2 * FB * CPB);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(80000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [15:0] w4;
        reset = 1'b1; up_idx = 0; up_last = 100; up_off = 1'b1; rd_pulses = 0;
        drive_up();
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rd_clk", rd_clk, 1'b0);
        check("reset_done", done, 1'b0);

        // A55A, rd_en dropped 1000 cycles into the word
        up_words = {16'hA55A, 16'hA55A, 16'hA55A};
        up_idx = 0; up_last = 100; up_off = 1'b0;
        push_word(16'hA55A);
        drive_up();
        reset = 1'b0;
        n = 0;
        while (rd_pulses < 1 && n < 100) begin @(negedge clk); n++; end
        check("t1_rd_clk_timeout", n < 100, 1'b1);
        repeat (1000) @(negedge clk);
        up_off = 1'b1;
        drive_up();
        n = 0;
        while (rx_q.size() < 2 && n < 8000) begin @(negedge clk); n++; end
        check("t1_word_timeout", n < 8000, 1'b1);
        repeat (3000) @(negedge clk);
        check("t1_hi_byte", rx_q[0], 8'hA5);
        check("t1_lo_byte", rx_q[1], 8'h5A);
        check("t1_word_len_lit", last_len, WORD_LEN_LIT);
        check("t1_rd_pulses", rd_pulses, 1);
        check("t1_idle_tx", tx, 1'b1);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_done", done, 1'b0);
        check("t1_leftover", exp_q.size(), 0);

        // Three words, ended with the third; a fourth is offered but must be ignored
        rx_q.delete(); rd_pulses = 0;
        up_words = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        up_idx = 0; up_last = 2; up_off = 1'b0;
        push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
        drive_up();
        n = 0;
        while (done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        check("t2_done_timeout", n < 20000, 1'b1);
        repeat (500) @(negedge clk);
        check("t2_rd_pulses", rd_pulses, 3);
        check("t2_b0", rx_q[0], 8'h00);
        check("t2_b1", rx_q[1], 8'h01);
        check("t2_b2", rx_q[2], 8'h00);
        check("t2_b3", rx_q[3], 8'h02);
        check("t2_b4", rx_q[4], 8'h00);
        check("t2_b5", rx_q[5], 8'h03);
        check("t2_rx_count", rx_q.size(), 6);
        check("t2_done", done, 1'b1);
        check("t2_tx_idle", tx, 1'b1);
        check("t2_busy", busy, 1'b0);

        // Reset clears sticky done
        reset = 1'b1;
        #1;
        check("t3_done_cleared", done, 1'b0);
        @(negedge clk);
        rx_q.delete(); rd_pulses = 0;
        up_words = {16'h0034, 16'h0035};
        up_idx = 0; up_last = 0; up_off = 1'b0;
        push_word(16'h0034);
        drive_up();
        reset = 1'b0;
        n = 0;
        while (rd_pulses < 1 && n < 100) begin @(negedge clk); n++; end
        check("t3_rd_clk_timeout", n < 100, 1'b1);
        repeat (500) @(negedge clk);
        check("t3_tx_low_before_reset", tx, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t3_tx_async_high", tx, 1'b1);
        check("t3_busy_reset", busy, 1'b0);
        check("t3_rd_clk_reset", rd_clk, 1'b0);
        check("t3_done_reset", done, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rx_q.delete();

        // ended already high when the first word is latched: one word then done
`ifdef UART_PARITY_EN
        w4 = 16'h0700;
`else
        w4 = 16'hC381;
`endif
        rd_pulses = 0;
        up_words = {w4, 16'h1111};
        up_idx = 0; up_last = 0; up_off = 1'b0;
        push_word(w4);
        drive_up();
        reset = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        check("t4_done_timeout", n < 8000, 1'b1);
        repeat (300) @(negedge clk);
        check("t4_rd_pulses", rd_pulses, 1);
        check("t4_rx_count", rx_q.size(), 2);
        check("t4_hi_byte", rx_q[0], w4[15:8]);
        check("t4_lo_byte", rx_q[1], w4[7:0]);
        check("t4_word_len_lit", last_len, WORD_LEN_LIT);
        check("t4_tx_idle", tx, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter CLK_FREQ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Parameter SETTLE, default 4, clk cycles waited after a read request before the next word is latched.
REQ-004 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_en  input  1  upstream buffer has a valid word on data_in.
REQ-007 data_in  input  16  word from the upstream post-process buffer.
REQ-008 ended  input  1  upstream signals the final word has been presented.
REQ-009 rd_clk  output  1  read-request pulse; upstream advances its read address on the rising edge.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high while a word is being serialised.
REQ-012 done  output  1  high once the stream is complete; sticky until reset.

Function
REQ-013 CLKS_PER_BIT SHALL be floor(CLK_FREQ/BAUD), 234 at the defaults; the bit counter is sized to hold CLKS_PER_BIT-1.
REQ-014 FSM states SHALL be IDLE, LATCH, REQ, WAIT, START, DATA, PAR, STOP, FIN.
REQ-015 IDLE->LATCH when rd_en=1 and done=0; otherwise remain in IDLE with tx=1 and busy=0.
REQ-016 LATCH SHALL capture data_in into a 16-bit shadow register and sample ended into a last flag, then go to REQ.
REQ-017 REQ SHALL drive rd_clk=1 for exactly one cycle, then go to START; rd_clk is 0 in every other state.
REQ-018 Each word SHALL be sent as two 8N1 frames: high byte first, then low byte; bits within a byte go LSB first.
REQ-019 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles.
REQ-020 After the stop bit of the high byte, the FSM SHALL return to START for the low byte with no idle gap.
REQ-021 After the stop bit of the low byte: if the last flag is 1, go to FIN; otherwise go to WAIT.
REQ-022 WAIT SHALL hold for SETTLE cycles, then go to LATCH if rd_en=1, else to IDLE.
REQ-023 FIN SHALL set done=1 and return to IDLE; with done=1 no further words are latched.
REQ-024 If rd_en falls mid-word, the current word SHALL complete; the fall is only evaluated at the end of WAIT.
REQ-025 If ended rises mid-word, the current word SHALL complete and exactly one further word SHALL be latched and sent, with its last flag set.
REQ-026 busy SHALL be 1 from LATCH through the final STOP cycle inclusive.

Reset
REQ-027 On reset: state=IDLE, tx=1, rd_clk=0, busy=0, done=0; shadow register, bit counter and byte index are cleared.
REQ-028 If reset is asserted mid-frame, tx SHALL go high asynchronously, without waiting for a clock edge.

Configuration
REQ-029 With UART_PARITY_EN defined, state PAR SHALL insert one even-parity bit (CLKS_PER_BIT cycles) between the last data bit and the stop bit; frame = 11 bits.
REQ-030 Without UART_PARITY_EN, PAR SHALL be unreachable and the frame is 10 bits.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state encoding, the CLKS_PER_BIT calculation and the frame-length constants.
REQ-032 Bit timing SHALL be implemented in sub-module uart_baud_tick (counter plus one-cycle tick output, restartable at START).

Verification
REQ-033 Defaults, rd_en=1, data_in=16'hA55A, ended=0 -> tx carries byte 0xA5 then 0x5A, each bit 234 cycles; word = 4680 cycles; one rd_clk pulse, 1 cycle wide.
REQ-034 Three words 0x0001, 0x0002, 0x0003, ended asserted with the third -> exactly 3 rd_clk pulses, bytes 00 01 00 02 00 03, then done=1 and tx idle high.
REQ-035 rd_en deasserted 1000 cycles into a word -> word completes, FSM returns to IDLE after SETTLE cycles, no further rd_clk.
REQ-036 reset asserted 500 cycles into a frame -> tx=1 before the next clk edge; all outputs at reset values; a clean restart follows release.
REQ-037 UART_PARITY_EN defined, data_in=16'h0700 -> parity bit 1 for 0x07 and 0 for 0x00; word = 5148 cycles.
REQ-038 ended=1 at the same cycle as LATCH of the first word -> exactly one word is sent, then done=1.
